// File: rtl/arb_pkg.sv
// arb_pkg: shared types, default parameters and helpers for the bus arbiter.
package arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
    localparam int DEF_NUM_MASTERS = 3;
    localparam int DEF_ID_WIDTH = 2;
    localparam int DEF_TIMEOUT_LEN = 6;
    localparam int MAX_MASTERS = 8;
    function automatic int ones_count(input logic [MAX_MASTERS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_MASTERS; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/arb_priority_picker.sv
// arb_priority_picker: rotate-then-priority-encode; the first requester at or after start wins.
module arb_priority_picker
    import arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]    start,
    output logic [ID_WIDTH-1:0]    idx,
    output logic                   valid
);
    always_comb begin
        int j;
        j = 0;
        idx = '0;
        valid = |req;
        // Scan from the far end so the candidate nearest to start is written last.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NUM_MASTERS) j -= NUM_MASTERS;
            if (req[j]) idx = ID_WIDTH'(j);
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: request/grant arbiter with idle-owner timeout and registered one-hot grant.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ID_WIDTH = DEF_ID_WIDTH,
    parameter int TIMEOUT_LEN = DEF_TIMEOUT_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] b_request,
    input  logic                   b_bus_utilizing,
    output logic [NUM_MASTERS-1:0] b_grant,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   bus_owned,
    output logic                   timeout_evt
);
    localparam logic [TIMEOUT_LEN-1:0] LIMIT = '1;
    state_t state, state_nxt;
    logic [TIMEOUT_LEN-1:0] cnt, cnt_nxt;
    logic [ID_WIDTH-1:0] start, win_id, id_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic win_valid, owner_req, timed_out, owned_nxt, evt_nxt;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] last_owner;
    always_ff @(posedge clk)
        if (rst) last_owner <= ID_WIDTH'(NUM_MASTERS - 1);
        else if (state == GRANT && state_nxt == RELEASE) last_owner <= grant_id;
    assign start = (last_owner == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : last_owner + ID_WIDTH'(1);
`else
    assign start = '0;
`endif

    arb_priority_picker #(.NUM_MASTERS(NUM_MASTERS), .ID_WIDTH(ID_WIDTH)) u_picker (
        .req(b_request),
        .start(start),
        .idx(win_id),
        .valid(win_valid)
    );

    assign owner_req = b_request[grant_id];
    assign timed_out = cnt == LIMIT;

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            b_grant <= '0;
            grant_id <= '0;
            bus_owned <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            b_grant <= grant_nxt;
            grant_id <= id_nxt;
            bus_owned <= owned_nxt;
            timeout_evt <= evt_nxt;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_valid ? GRANT : IDLE;
            GRANT:   state_nxt = (!owner_req || timed_out) ? RELEASE : GRANT;
            RELEASE: state_nxt = b_bus_utilizing ? RELEASE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; a request drop masks the timeout pulse.
    always_comb begin
        grant_nxt = '0;
        id_nxt = grant_id;
        owned_nxt = 1'b0;
        cnt_nxt = '0;
        if (state == IDLE && win_valid) begin
            grant_nxt[win_id] = 1'b1;
            id_nxt = win_id;
            owned_nxt = 1'b1;
        end
        if (state == GRANT && state_nxt == GRANT) begin
            grant_nxt = b_grant;
            owned_nxt = 1'b1;
        end
        if (state == GRANT) cnt_nxt = b_bus_utilizing ? '0 : (timed_out ? cnt : cnt + TIMEOUT_LEN'(1));
        evt_nxt = state == GRANT && owner_req && timed_out;
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) ones_count(MAX_MASTERS'(b_grant)) <= 1);
endmodule
